wb_port_arbiter: RTL and testbench

WB_PORT_ARBITER -- requirements
Module: wb_port_arbiter

---
 rtl/wb_port_arbiter.sv | 83 ++++++++
 tb/tb_wb_port_arbiter.sv | 191 +++++++++++++++++++
 2 files changed

// File: rtl/wb_port_arbiter.sv
// Two-source register-file writeback arbiter (ALU, LSU); latency 1, registered we3/a3/wd3.
// Backpressure: refused sources hold their request; the LSU wins after MAX_WAIT refused cycles.
module wb_port_arbiter #(
  parameter int MAX_WAIT = 4
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        alu_valid,
  input  logic [4:0]  alu_rd,
  input  logic [31:0] alu_data,
  output logic        alu_ready,
  input  logic        lsu_valid,
  input  logic [4:0]  lsu_rd,
  input  logic [31:0] lsu_data,
  output logic        lsu_ready,
  output logic        we3,
  output logic [4:0]  a3,
  output logic [31:0] wd3,
  output logic        alu_stall
);

  localparam logic [3:0] MAX_WAIT_C = 4'(MAX_WAIT);

  logic [3:0]  wait_cnt_q, wait_cnt_d;
  logic        we3_q, we3_d;
  logic [4:0]  a3_q, a3_d;
  logic [31:0] wd3_q, wd3_d;
  logic        lsu_force;
  logic        alu_grant;
  logic        lsu_grant;

  always_comb begin
    lsu_force = lsu_valid && (wait_cnt_q == MAX_WAIT_C);
    // Both grants are suppressed during reset so no transfer can be taken.
    alu_grant = !rst && alu_valid && !lsu_force;
    lsu_grant = !rst && lsu_valid && (!alu_valid || lsu_force);
  end

  always_comb begin
    wait_cnt_d = wait_cnt_q;
    we3_d      = 1'b0;
    a3_d       = a3_q;
    wd3_d      = wd3_q;

    if (!lsu_valid || lsu_grant) begin
      wait_cnt_d = 4'd0;
    end else if (wait_cnt_q != MAX_WAIT_C) begin
      wait_cnt_d = wait_cnt_q + 4'd1;
    end

    if (alu_grant) begin
      we3_d = (alu_rd != 5'd0);
      a3_d  = alu_rd;
      wd3_d = alu_data;
    end else if (lsu_grant) begin
      we3_d = (lsu_rd != 5'd0);
      a3_d  = lsu_rd;
      wd3_d = lsu_data;
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      wait_cnt_q <= 4'd0;
      we3_q      <= 1'b0;
      a3_q       <= 5'd0;
      wd3_q      <= 32'd0;
    end else begin
      wait_cnt_q <= wait_cnt_d;
      we3_q      <= we3_d;
      a3_q       <= a3_d;
      wd3_q      <= wd3_d;
    end
  end

  assign alu_ready = alu_grant;
  assign lsu_ready = lsu_grant;
  assign alu_stall = alu_valid && !alu_grant;
  assign we3       = we3_q;
  assign a3        = a3_q;
  assign wd3       = wd3_q;

endmodule

// File: tb/tb_wb_port_arbiter.sv
// Bench for wb_port_arbiter: directed vectors plus randomized traffic against a
// model that tracks how long the LSU has been refused and the ordered list of writes.
module tb_wb_port_arbiter;
  localparam int MAX_WAIT = 4;

  logic        clk = 1'b0;
  logic        rst = 1'b1;
  logic        alu_valid = 1'b0;
  logic [4:0]  alu_rd = '0;
  logic [31:0] alu_data = '0;
  logic        alu_ready;
  logic        lsu_valid = 1'b0;
  logic [4:0]  lsu_rd = '0;
  logic [31:0] lsu_data = '0;
  logic        lsu_ready;
  logic        we3;
  logic [4:0]  a3;
  logic [31:0] wd3;
  logic        alu_stall;

  int total_cnt = 0;
  int pass_cnt  = 0;

  // Model state: refused LSU cycles so far, expected registered outputs, pending writes.
  int          lsu_refused = 0;
  int          dut_lat = 0;
  logic        exp_we = 1'b0;
  logic [4:0]  exp_a3 = '0;
  logic [31:0] exp_wd3 = '0;
  logic        last_ar = 1'b0;
  logic        last_lr = 1'b0;
  logic        obs_lr = 1'b0;
  logic [36:0] wq[$];
  logic [31:0] rf_dut[32];
  logic [31:0] rf_ref[32];

  wb_port_arbiter #(.MAX_WAIT(MAX_WAIT)) dut (
    .clk(clk), .rst(rst),
    .alu_valid(alu_valid), .alu_rd(alu_rd), .alu_data(alu_data), .alu_ready(alu_ready),
    .lsu_valid(lsu_valid), .lsu_rd(lsu_rd), .lsu_data(lsu_data), .lsu_ready(lsu_ready),
    .we3(we3), .a3(a3), .wd3(wd3), .alu_stall(alu_stall)
  );

  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    total_cnt++;
    assert (obs === exp) pass_cnt++;
    else $error("FAIL %s: got 0x%0h expected 0x%0h", tag, obs, exp);
  endtask

  task automatic cycle(input logic r, input logic av, input logic [4:0] ard, input logic [31:0] ad,
                       input logic lv, input logic [4:0] lrd, input logic [31:0] ld);
    logic fp, ear, elr;
    logic [36:0] w;
    rst = r; alu_valid = av; alu_rd = ard; alu_data = ad;
    lsu_valid = lv; lsu_rd = lrd; lsu_data = ld;
    #2;
    // LSU wins once it has been refused MAX_WAIT times in a row.
    fp  = lv && (lsu_refused >= MAX_WAIT);
    ear = !r && av && !fp;
    elr = !r && lv && (!av || fp);
    chk("alu_ready", alu_ready, ear);
    chk("lsu_ready", lsu_ready, elr);
    chk("alu_stall", alu_stall, av && !ear);
    obs_lr = lsu_ready;
    if (r || !lv) begin
      dut_lat = 0;
    end else begin
      dut_lat++;
      if (lsu_ready === 1'b1) begin
        chk("lsu_latency_ok", dut_lat <= MAX_WAIT + 1, 1);
        dut_lat = 0;
      end
    end
    if (ear && ard != 0) wq.push_back({ard, ad});
    else if (elr && lrd != 0) wq.push_back({lrd, ld});

    @(posedge clk); #1;
    if (r) begin
      exp_we = 1'b0; exp_a3 = '0; exp_wd3 = '0;
    end else if (ear) begin
      exp_we = (ard != 0); exp_a3 = ard; exp_wd3 = ad;
    end else if (elr) begin
      exp_we = (lrd != 0); exp_a3 = lrd; exp_wd3 = ld;
    end else begin
      exp_we = 1'b0;
    end
    lsu_refused = (!r && lv && !elr) ? lsu_refused + 1 : 0;
    last_ar = ear;
    last_lr = elr;
    chk("we3", we3, exp_we);
    chk("a3", a3, exp_a3);
    chk("wd3", wd3, exp_wd3);
    if (we3 === 1'b1) begin
      chk("pending_writes", wq.size(), 1);
      if (wq.size() > 0) begin
        w = wq.pop_front();
        chk("write_rd", a3, w[36:32]);
        chk("write_data", wd3, w[31:0]);
        rf_ref[w[36:32]] = w[31:0];
      end
      rf_dut[a3] = wd3;
    end
    chk("lost_writes", wq.size(), 0);
    wq.delete();
  endtask

  initial begin
    logic        av, lv, r;
    logic [4:0]  ard, lrd;
    logic [31:0] ad, ld;
    for (int k = 0; k < 32; k++) begin
      rf_dut[k] = '0;
      rf_ref[k] = '0;
    end

    // Reset with ALU requesting: no grants, stall follows alu_valid, outputs cleared.
    cycle(1, 1, 5'd9, 32'h1, 1, 5'd2, 32'h2);
    cycle(1, 1, 5'd9, 32'h1, 0, 5'd2, 32'h2);
    chk("reset_we3", we3, 0);
    chk("reset_a3", a3, 0);
    chk("reset_wd3", wd3, 0);

    // ALU only.
    cycle(0, 1, 5'd5, 32'hDEADBEEF, 0, 5'd0, 32'h0);
    chk("alu_only_we3", we3, 1);
    chk("alu_only_a3", a3, 5);
    chk("alu_only_wd3", wd3, 32'hDEADBEEF);
    cycle(0, 0, 5'd0, 32'h0, 0, 5'd0, 32'h0);
    chk("idle_we3", we3, 0);
    chk("idle_hold_a3", a3, 5);
    chk("idle_hold_wd3", wd3, 32'hDEADBEEF);

    // Continuous ALU traffic: LSU granted on its fifth cycle.
    for (int k = 0; k < 5; k++) begin
      cycle(0, 1, 5'd3, 32'h11, 1, 5'd4, 32'h22);
      chk("starve_lsu_grant", obs_lr, (k == 4));
    end
    chk("starve_a3", a3, 4);
    chk("starve_wd3", wd3, 32'h22);
    cycle(0, 0, 5'd0, 32'h0, 0, 5'd0, 32'h0);

    // LSU only to x0: handshake completes, no write.
    cycle(0, 0, 5'd0, 32'h0, 1, 5'd0, 32'h1234);
    chk("lsu_x0_grant", obs_lr, 1);
    chk("lsu_x0_we3", we3, 0);

    // Same rd from both: ALU write first, LSU the next cycle.
    cycle(0, 1, 5'd7, 32'hAA, 1, 5'd7, 32'hBB);
    chk("same_rd_first", wd3, 32'hAA);
    cycle(0, 0, 5'd0, 32'h0, 1, 5'd7, 32'hBB);
    chk("same_rd_second", wd3, 32'hBB);
    chk("same_rd_we3", we3, 1);
    cycle(0, 0, 5'd0, 32'h0, 0, 5'd0, 32'h0);

    // Reset in the middle of an LSU wait discards the accumulated priority.
    cycle(0, 1, 5'd1, 32'h10, 1, 5'd2, 32'h20);
    cycle(0, 1, 5'd1, 32'h10, 1, 5'd2, 32'h20);
    cycle(1, 1, 5'd1, 32'h10, 1, 5'd2, 32'h20);
    chk("mid_reset_we3", we3, 0);
    for (int k = 0; k < 5; k++) begin
      cycle(0, 1, 5'd1, 32'h10, 1, 5'd2, 32'h20);
      chk("post_reset_lsu_grant", obs_lr, (k == 4));
    end
    cycle(0, 0, 5'd0, 32'h0, 0, 5'd0, 32'h0);

    // Randomized traffic; refused requests are held until granted.
    av = 0; lv = 0; ard = 0; lrd = 0; ad = 0; ld = 0;
    for (int i = 0; i < 800; i++) begin
      r = ($urandom_range(0, 63) == 0);
      if (!(av && !last_ar)) begin
        av  = ($urandom_range(0, 3) != 0);
        ard = 5'($urandom_range(0, 7));
        ad  = $urandom;
      end
      if (!(lv && !last_lr)) begin
        lv  = ($urandom_range(0, 1) != 0);
        lrd = 5'($urandom_range(0, 7));
        ld  = $urandom;
      end
      cycle(r, av, ard, ad, lv, lrd, ld);
    end
    cycle(0, 0, 5'd0, 32'h0, 0, 5'd0, 32'h0);

    for (int k = 0; k < 32; k++) chk("regfile_final", rf_dut[k], rf_ref[k]);

    $display("%0d/%0d checks passed", pass_cnt, total_cnt);
    $finish;
  end
endmodule
